game_controller: RTL and testbench

- Sequences the per-frame bird physics and game state machine of the flappy bird design.
- Sits in logic_top between video timing (frame_start pulse), the debounced flap button, the collision/pipe detectors from the renderer, and the sprite renderer that consumes bird_y.
- Performs one physics step per video frame.
- Owns the IDLE/PLAY/DEAD sequencing, the score and the status LEDs.

---
 rtl/game_controller_pkg.sv | 8 +
 rtl/game_controller_if.sv | 23 ++
 rtl/game_controller_bird_physics.sv | 53 +++++
 rtl/game_controller.sv | 90 +++++++++
 tb/tb_game_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_controller_pkg.sv
// game_pkg: shared state/step encodings and default screen geometry for the game controller
package game_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, DEAD} game_state_t;
  typedef enum logic [1:0] {STEP_IDLE, STEP_VEL, STEP_POS, STEP_DONE} step_t;
  localparam int SCREEN_H = 720;
  localparam int BIRD_H = 16;
  localparam int START_Y = 352;
endpackage

// File: rtl/game_controller_if.sv
// game_controller_if: frame/button/detector inputs and bird/state/score outputs of the controller
interface game_controller_if #(
  parameter int Y_W = 10,
  parameter int SCORE_W = 8
);
  logic frame_start;
  logic flap;
  logic collision;
  logic pipe_passed;
  logic [Y_W-1:0] bird_y;
  logic [1:0] state;
  logic [SCORE_W-1:0] score;
  logic update_done;
  logic [5:0] leds;
  modport master (
    output frame_start, flap, collision, pipe_passed,
    input bird_y, state, score, update_done, leds
  );
  modport slave (
    input frame_start, flap, collision, pipe_passed,
    output bird_y, state, score, update_done, leds
  );
endinterface

// File: rtl/game_controller_bird_physics.sv
// bird_physics: per-frame velocity and position update with ceiling/floor clamping
module bird_physics #(
  parameter int Y_W = 10,
  parameter int VEL_W = 6,
  parameter int SCREEN_H = game_pkg::SCREEN_H,
  parameter int BIRD_H = game_pkg::BIRD_H,
  parameter int START_Y = game_pkg::START_Y,
  parameter int GRAVITY = 1,
  parameter int FLAP_VEL = -10,
  parameter int MAX_FALL = 12
) (
  input  logic clk_27M,
  input  logic rst,
  input  logic init_i,
  input  logic flap_i,
  input  game_pkg::step_t step_i,
  output logic [Y_W-1:0] bird_y_o,
  output logic floor_hit_o
);
  import game_pkg::*;
  localparam logic signed [VEL_W:0] MAX_V = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [VEL_W:0] GRAV_V = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W-1:0] FLAP_V = VEL_W'(FLAP_VEL);
  localparam logic signed [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - BIRD_H);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [Y_W-1:0] y_q, y_d;
  logic signed [VEL_W:0] vel_inc;
  logic signed [Y_W:0] next_y;
  // one extra bit on both sums keeps overflow visible for saturation and clamping
  always_comb begin
    vel_inc = {vel_q[VEL_W-1], vel_q} + GRAV_V;
    next_y = $signed({1'b0, y_q}) + $signed({{(Y_W+1-VEL_W){vel_q[VEL_W-1]}}, vel_q});
    floor_hit_o = step_i == STEP_POS && next_y > Y_MAX;
    vel_d = init_i ? '0
          : step_i == STEP_VEL ? (flap_i ? FLAP_V : vel_inc > MAX_V ? MAX_V[VEL_W-1:0] : vel_inc[VEL_W-1:0])
          : (step_i == STEP_POS && next_y[Y_W]) ? '0 : vel_q;
    y_d = init_i ? Y_START
        : step_i != STEP_POS ? y_q
        : next_y[Y_W] ? '0
        : floor_hit_o ? Y_MAX[Y_W-1:0] : next_y[Y_W-1:0];
  end
  always_ff @(posedge clk_27M) begin
    if (rst) begin
      y_q <= Y_START;
      vel_q <= '0;
    end else begin
      y_q <= y_d;
      vel_q <= vel_d;
    end
  end
  assign bird_y_o = y_q;
endmodule

// File: rtl/game_controller.sv
// game_controller: IDLE/PLAY/DEAD sequencing, per-frame physics stepping, score and status leds
module game_controller #(
  parameter int Y_W = 10,
  parameter int VEL_W = 6,
  parameter int SCORE_W = 8,
  parameter int SCREEN_H = game_pkg::SCREEN_H,
  parameter int BIRD_H = game_pkg::BIRD_H,
  parameter int START_Y = game_pkg::START_Y,
  parameter int GRAVITY = 1,
  parameter int FLAP_VEL = -10,
  parameter int MAX_FALL = 12,
  parameter int DEAD_FRAMES = 60
) (
  input  logic clk_27M,
  input  logic rst,
  game_controller_if.slave bus
);
  import game_pkg::*;
  localparam int DW = $clog2(DEAD_FRAMES + 1);
  localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_FRAMES);
  game_state_t state_q, state_d;
  step_t step_q, step_d;
  logic flap_q, pend_q, pend_d, done_q, floor_hit, flap_edge;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [5:0] leds_q, leds_d;
  assign flap_edge = bus.flap & ~flap_q;
  always_comb begin
    state_d = state_q;
    pend_d = (pend_q && step_q != STEP_VEL) || flap_edge;
    score_d = (state_q == PLAY && bus.pipe_passed && score_q != '1) ? score_q + 1'b1 : score_q;
    dead_d = dead_q;
    step_d = step_q == STEP_VEL ? STEP_POS
           : step_q == STEP_POS ? STEP_DONE
           : (state_q == PLAY && step_q == STEP_IDLE && bus.frame_start && !bus.collision) ? STEP_VEL
           : STEP_IDLE;
    leds_d = {score_q[2:0], state_q == DEAD, state_q == PLAY, state_q == IDLE};
    case (state_q)
      IDLE: state_d = flap_edge ? PLAY : IDLE;
      PLAY: state_d = ((step_q == STEP_IDLE && bus.frame_start && bus.collision) || floor_hit) ? DEAD : PLAY;
      DEAD: begin
        pend_d = 1'b0;
        dead_d = (bus.frame_start && dead_q < DEAD_MAX) ? dead_q + 1'b1 : dead_q;
        if (flap_edge && dead_q == DEAD_MAX) begin
          state_d = IDLE;
          score_d = '0;
          dead_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_27M) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= STEP_IDLE;
      flap_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      score_q <= '0;
      dead_q <= '0;
      leds_q <= 6'b000001;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      flap_q <= bus.flap;
      pend_q <= pend_d;
      done_q <= step_q == STEP_POS;
      score_q <= score_d;
      dead_q <= dead_d;
      leds_q <= leds_d;
    end
  end
  bird_physics #(
    .Y_W(Y_W), .VEL_W(VEL_W), .SCREEN_H(SCREEN_H), .BIRD_H(BIRD_H), .START_Y(START_Y),
    .GRAVITY(GRAVITY), .FLAP_VEL(FLAP_VEL), .MAX_FALL(MAX_FALL)
  ) u_physics (
    .clk_27M(clk_27M),
    .rst(rst),
    .init_i(state_d == IDLE),
    .flap_i(pend_q),
    .step_i(step_q),
    .bird_y_o(bus.bird_y),
    .floor_hit_o(floor_hit)
  );
  assign bus.state = state_q;
  assign bus.score = score_q;
  assign bus.update_done = done_q;
  assign bus.leds = leds_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed scenario tests of game_controller against hand-computed values
module tb_game_controller;
  logic clk_27M = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int y_m = 352;
  int v_m = 0;
  int lat, nd, prev, tot;
  game_controller_if #(.Y_W(10), .SCORE_W(8)) bus ();
  game_controller dut (.clk_27M(clk_27M), .rst(rst), .bus(bus));
  always #5 clk_27M = ~clk_27M;

  task automatic tick;
    @(negedge clk_27M);
  endtask

  task automatic flap_pulse;
    bus.flap = 1'b1;
    tick;
    bus.flap = 1'b0;
    tick;
  endtask

  task automatic pipe;
    bus.pipe_passed = 1'b1;
    tick;
    bus.pipe_passed = 1'b0;
  endtask

  task automatic model_step(input bit fl);
    v_m = fl ? -10 : (v_m + 1 > 12 ? 12 : v_m + 1);
    y_m = y_m + v_m;
    if (y_m < 0) begin
      y_m = 0;
      v_m = 0;
    end else if (y_m > 704) y_m = 704;
  endtask

  // optional flap edge, then one frame_start; reports first update_done latency and pulse count
  task automatic run_frame(input bit fl, input bit col, input bit extra, output int l, output int n);
    if (fl) begin
      bus.flap = 1'b1;
      tick;
      bus.flap = 1'b0;
    end
    bus.frame_start = 1'b1;
    bus.collision = col;
    tick;
    bus.frame_start = extra;
    bus.collision = 1'b0;
    l = 0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) bus.frame_start = 1'b0;
      if (bus.update_done) begin
        n++;
        if (l == 0) l = i;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    bus.frame_start = 1'b0; bus.flap = 1'b0; bus.collision = 1'b0; bus.pipe_passed = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    checks++; if (int'(bus.bird_y) !== 352) begin errors++; $display("FAIL reset_bird_y got=%0d exp=352", bus.bird_y); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.leds !== 6'b000001) begin errors++; $display("FAIL reset_leds got=%b exp=000001", bus.leds); end
    checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
    checks++; if (bus.update_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.update_done); end
    tot = 0;
    repeat (5) begin
      run_frame(1'b0, 1'b0, 1'b0, lat, nd);
      tot += nd;
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL idle_no_done got=%0d exp=0", tot); end
    checks++; if (int'(bus.bird_y) !== 352) begin errors++; $display("FAIL idle_bird_y got=%0d exp=352", bus.bird_y); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_start;
    bus.flap = 1'b1;
    tick;
    bus.flap = 1'b0;
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", bus.state); end
    checks++; if (bus.leds !== 6'b000001) begin errors++; $display("FAIL start_leds_lag got=%b exp=000001", bus.leds); end
    tick;
    checks++; if (bus.leds !== 6'b000010) begin errors++; $display("FAIL start_leds got=%b exp=000010", bus.leds); end
    run_frame(1'b0, 1'b0, 1'b0, lat, nd);
    model_step(1'b1);
    checks++; if (lat !== 3) begin errors++; $display("FAIL start_latency got=%0d exp=3", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL start_done_count got=%0d exp=1", nd); end
    checks++; if (int'(bus.bird_y) !== 342) begin errors++; $display("FAIL start_bird_y got=%0d exp=342", bus.bird_y); end
  endtask

  task automatic test_gravity;
    for (int k = 1; k <= 30; k++) begin
      prev = int'(bus.bird_y);
      run_frame(1'b0, 1'b0, 1'b0, lat, nd);
      model_step(1'b0);
      checks++; if (int'(bus.bird_y) !== y_m) begin errors++; $display("FAIL gravity_y frame=%0d got=%0d exp=%0d", k, bus.bird_y, y_m); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL gravity_latency frame=%0d got=%0d exp=3", k, lat); end
      if (k == 21) begin
        checks++; if (int'(bus.bird_y) - prev !== 11) begin errors++; $display("FAIL gravity_vel21 got=%0d exp=11", int'(bus.bird_y) - prev); end
      end
      if (k == 22 || k == 30) begin
        checks++; if (int'(bus.bird_y) - prev !== 12) begin errors++; $display("FAIL gravity_vel_sat frame=%0d got=%0d exp=12", k, int'(bus.bird_y) - prev); end
      end
    end
    checks++; if (int'(bus.bird_y) !== 471) begin errors++; $display("FAIL gravity_final got=%0d exp=471", bus.bird_y); end
  endtask

  task automatic test_back_to_back;
    run_frame(1'b0, 1'b0, 1'b1, lat, nd);
    model_step(1'b0);
    checks++; if (nd !== 1) begin errors++; $display("FAIL inflight_done_count got=%0d exp=1", nd); end
    checks++; if (int'(bus.bird_y) !== 483) begin errors++; $display("FAIL inflight_bird_y got=%0d exp=483", bus.bird_y); end
  endtask

  task automatic test_ceiling;
    for (int k = 0; k < 60 && y_m > 0; k++) begin
      run_frame(1'b1, 1'b0, 1'b0, lat, nd);
      model_step(1'b1);
      checks++; if (int'(bus.bird_y) !== y_m) begin errors++; $display("FAIL ceiling_y step=%0d got=%0d exp=%0d", k, bus.bird_y, y_m); end
    end
    checks++; if (int'(bus.bird_y) !== 0) begin errors++; $display("FAIL ceiling_clamp got=%0d exp=0", bus.bird_y); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL ceiling_state got=%0d exp=1", bus.state); end
    run_frame(1'b0, 1'b0, 1'b0, lat, nd);
    model_step(1'b0);
    checks++; if (int'(bus.bird_y) !== 1) begin errors++; $display("FAIL ceiling_vel_zero got=%0d exp=1", bus.bird_y); end
  endtask

  task automatic test_floor;
    pipe;
    pipe;
    for (int k = 0; k < 100 && y_m < 704; k++) begin
      run_frame(1'b0, 1'b0, 1'b0, lat, nd);
      model_step(1'b0);
      checks++; if (int'(bus.bird_y) !== y_m) begin errors++; $display("FAIL floor_y step=%0d got=%0d exp=%0d", k, bus.bird_y, y_m); end
      if (y_m == 704) begin
        checks++; if (nd !== 1) begin errors++; $display("FAIL floor_done got=%0d exp=1", nd); end
      end
    end
    checks++; if (int'(bus.bird_y) !== 704) begin errors++; $display("FAIL floor_clamp got=%0d exp=704", bus.bird_y); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL floor_state got=%0d exp=2", bus.state); end
    checks++; if (bus.score !== 8'd2) begin errors++; $display("FAIL floor_score got=%0d exp=2", bus.score); end
    pipe;
    tick;
    checks++; if (bus.score !== 8'd2) begin errors++; $display("FAIL dead_score_frozen got=%0d exp=2", bus.score); end
    run_frame(1'b0, 1'b0, 1'b0, lat, nd);
    checks++; if (nd !== 0) begin errors++; $display("FAIL dead_no_done got=%0d exp=0", nd); end
    checks++; if (int'(bus.bird_y) !== 704) begin errors++; $display("FAIL dead_y_frozen got=%0d exp=704", bus.bird_y); end
  endtask

  task automatic test_dead_restart;
    for (int n = 2; n <= 59; n++) begin
      run_frame(1'b0, 1'b0, 1'b0, lat, nd);
      if (n == 10) begin
        flap_pulse;
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL dead_flap_early got=%0d exp=2", bus.state); end
      end
    end
    flap_pulse;
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL dead_flap_59 got=%0d exp=2", bus.state); end
    run_frame(1'b0, 1'b0, 1'b0, lat, nd);
    flap_pulse;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL restart_state got=%0d exp=0", bus.state); end
    checks++; if (int'(bus.bird_y) !== 352) begin errors++; $display("FAIL restart_bird_y got=%0d exp=352", bus.bird_y); end
    checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL restart_score got=%0d exp=0", bus.score); end
    checks++; if (bus.leds !== 6'b000001) begin errors++; $display("FAIL restart_leds got=%b exp=000001", bus.leds); end
    run_frame(1'b0, 1'b0, 1'b0, lat, nd);
    checks++; if (nd !== 0 || bus.state !== 2'd0) begin errors++; $display("FAIL restart_idle got=done%0d/state%0d exp=done0/state0", nd, bus.state); end
    y_m = 352;
    v_m = 0;
  endtask

  task automatic test_collision;
    flap_pulse;
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL coll_play got=%0d exp=1", bus.state); end
    repeat (3) pipe;
    tick;
    checks++; if (bus.score !== 8'd3) begin errors++; $display("FAIL coll_score got=%0d exp=3", bus.score); end
    checks++; if (bus.leds !== 6'b011010) begin errors++; $display("FAIL coll_leds got=%b exp=011010", bus.leds); end
    bus.frame_start = 1'b1;
    bus.collision = 1'b1;
    bus.pipe_passed = 1'b1;
    tick;
    bus.frame_start = 1'b0;
    bus.collision = 1'b0;
    bus.pipe_passed = 1'b0;
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL coll_state got=%0d exp=2", bus.state); end
    checks++; if (int'(bus.bird_y) !== 352) begin errors++; $display("FAIL coll_bird_y got=%0d exp=352", bus.bird_y); end
    checks++; if (bus.score !== 8'd4) begin errors++; $display("FAIL coll_pipe_same_cycle got=%0d exp=4", bus.score); end
    tot = 0;
    repeat (6) begin
      if (bus.update_done) tot++;
      tick;
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL coll_no_done got=%0d exp=0", tot); end
    checks++; if (bus.leds !== 6'b100100) begin errors++; $display("FAIL coll_dead_leds got=%b exp=100100", bus.leds); end
  endtask

  task automatic test_reset_mid_step;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    flap_pulse;
    pipe;
    tick;
    checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL midrst_pre_score got=%0d exp=1", bus.score); end
    bus.frame_start = 1'b1;
    tick;
    bus.frame_start = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (int'(bus.bird_y) !== 352) begin errors++; $display("FAIL midrst_bird_y got=%0d exp=352", bus.bird_y); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=0", bus.state); end
    checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL midrst_score got=%0d exp=0", bus.score); end
    checks++; if (bus.leds !== 6'b000001) begin errors++; $display("FAIL midrst_leds got=%b exp=000001", bus.leds); end
    tot = 0;
    repeat (6) begin
      if (bus.update_done) tot++;
      tick;
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", tot); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL midrst_stays_idle got=%0d exp=0", bus.state); end
    flap_pulse;
    run_frame(1'b0, 1'b0, 1'b0, lat, nd);
    checks++; if (int'(bus.bird_y) !== 342 || lat !== 3) begin errors++; $display("FAIL midrst_replay got=y%0d/lat%0d exp=y342/lat3", bus.bird_y, lat); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_gravity;
    test_back_to_back;
    test_ceiling;
    test_floor;
    test_dead_restart;
    test_collision;
    test_reset_mid_step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end
endmodule
